mem_bus_arbiter: RTL and testbench

- Shares the single Memory_Interface bus between two requesters: the core's instruction-fetch port (I) and its load/store port (D).
- Serialises their accesses with a request/ready handshake.
- Latches each granted request and drives the shared read/write/byte-enable/address/data bus for the required number of cycles.
- Returns read data to the requester that owns the transaction.
- Sits between the core and Memory_Interface. Memory is synchronous-read, clocked by iCLKMem.

---
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one synchronous-read memory bus between the
// instruction-fetch port (I) and the load/store port (D). Each granted request
// is latched, driven onto the bus for its access window, and answered with a
// one-cycle ready pulse to its owner. Conflicts alternate between the ports.
module mem_bus_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddress,
    output logic        oIReady,
    output logic [31:0] oIReadData,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic        oDReady,
    output logic [31:0] oDReadData,
    output logic        oMemReadEnable,
    output logic        oMemWriteEnable,
    output logic [3:0]  oMemByteEnable,
    output logic [31:0] oMemAddress,
    output logic [31:0] oMemWriteData,
    input  logic [31:0] iMemReadData,
    output logic        oBusy,
    output logic        oGrantD
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Remaining ACCESS cycles after the current one when a read is granted.
    localparam logic [3:0] READ_LAST = 4'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_d_q, grant_d_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        take_d;

    // Next-state logic: arbitration in IDLE, access timing in ACCESS, handback in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d_d = grant_d_q;
        write_d   = write_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        take_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // D wins when it is alone, or when both ask and I was served last.
                take_d = iDReq && (!iIReq || !grant_d_q);
                if (iIReq || iDReq) begin
                    grant_d_d = take_d;
                    state_d   = ACCESS;
                    if (take_d) begin
                        write_d = iDWrite;
                        addr_d  = iDAddress;
                        be_d    = iDByteEnable;
                        wdata_d = iDWriteData;
                        cnt_d   = iDWrite ? 4'd0 : READ_LAST;
                    end else begin
                        write_d = 1'b0;
                        addr_d  = iIAddress;
                        be_d    = 4'b1111;
                        cnt_d   = READ_LAST;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!write_q) begin
                        if (grant_d_q) begin
                            d_rdata_d = iMemReadData;
                        end else begin
                            i_rdata_d = iMemReadData;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-transaction registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            grant_d_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_d_q <= grant_d_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign oMemReadEnable  = (state_q == ACCESS) && !write_q;
    assign oMemWriteEnable = (state_q == ACCESS) && write_q;
    assign oMemAddress     = addr_q;
    assign oMemByteEnable  = be_q;
    assign oMemWriteData   = wdata_q;
    assign oIReady         = (state_q == DONE) && !grant_d_q;
    assign oDReady         = (state_q == DONE) && grant_d_q;
    assign oIReadData      = i_rdata_q;
    assign oDReadData      = d_rdata_q;
    assign oBusy           = (state_q != IDLE);
    assign oGrantD         = grant_d_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: drives both requesters with random and directed traffic
// and compares every output each cycle against a transaction-window model.
module tb_mem_bus_arbiter;

    localparam int RL = 3;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iIReq;
    logic [31:0] iIAddress;
    logic        oIReady;
    logic [31:0] oIReadData;
    logic        iDReq;
    logic        iDWrite;
    logic [3:0]  iDByteEnable;
    logic [31:0] iDAddress;
    logic [31:0] iDWriteData;
    logic        oDReady;
    logic [31:0] oDReadData;
    logic        oMemReadEnable;
    logic        oMemWriteEnable;
    logic [3:0]  oMemByteEnable;
    logic [31:0] oMemAddress;
    logic [31:0] oMemWriteData;
    logic [31:0] iMemReadData;
    logic        oBusy;
    logic        oGrantD;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one transaction granted at the end of cycle mG,
    // with its bus window, ready cycle and latched fields.
    bit          mInflight;
    int          mG;
    int          mLen;
    bit          mLastD;
    bit          mWrite;
    logic [31:0] mAddr;
    logic [3:0]  mBe;
    logic [31:0] mWdata;
    logic [31:0] mIrd;
    logic [31:0] mDrd;

    bit forceRst = 1'b0;
    bit midRstDone = 1'b0;
    logic [3:0] reRun = 4'd0;

    mem_bus_arbiter #(.READ_LATENCY(RL)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iIReq(iIReq),
        .iIAddress(iIAddress),
        .oIReady(oIReady),
        .oIReadData(oIReadData),
        .iDReq(iDReq),
        .iDWrite(iDWrite),
        .iDByteEnable(iDByteEnable),
        .iDAddress(iDAddress),
        .iDWriteData(iDWriteData),
        .oDReady(oDReady),
        .oDReadData(oDReadData),
        .oMemReadEnable(oMemReadEnable),
        .oMemWriteEnable(oMemWriteEnable),
        .oMemByteEnable(oMemByteEnable),
        .oMemAddress(oMemAddress),
        .oMemWriteData(oMemWriteData),
        .iMemReadData(iMemReadData),
        .oBusy(oBusy),
        .oGrantD(oGrantD)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0040_0004) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory stand-in: data is only valid on the last cycle of a read window.
    always @(posedge iCLK) reRun <= oMemReadEnable ? reRun + 4'd1 : 4'd0;
    assign iMemReadData = (oMemReadEnable && reRun == 4'(RL - 1)) ?
                          memWord(oMemAddress) : {16'hBAD0, 12'h000, reRun};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit readyI();
        return mInflight && !mLastD && (cyc == mG + mLen + 1);
    endfunction

    function automatic bit readyD();
        return mInflight && mLastD && (cyc == mG + mLen + 1);
    endfunction

    function automatic bit expWen();
        return mInflight && mWrite && (cyc == mG + 1);
    endfunction

    task automatic checkCycle();
        bit ren;
        ren = mInflight && !mWrite && (cyc <= mG + mLen);
        checkOutput("read_en", 32'(oMemReadEnable), 32'(ren));
        checkOutput("write_en", 32'(oMemWriteEnable), 32'(expWen()));
        checkOutput("address", oMemAddress, mAddr);
        checkOutput("byte_en", 32'(oMemByteEnable), 32'(mBe));
        if (expWen()) checkOutput("write_data", oMemWriteData, mWdata);
        checkOutput("i_ready", 32'(oIReady), 32'(readyI()));
        checkOutput("d_ready", 32'(oDReady), 32'(readyD()));
        checkOutput("busy", 32'(oBusy), 32'(mInflight));
        checkOutput("grant_d", 32'(oGrantD), 32'(mLastD));
        checkOutput("i_rdata", oIReadData, mIrd);
        checkOutput("d_rdata", oDReadData, mDrd);
    endtask

    task automatic newIReq();
        iIReq = 1'b1;
        iIAddress = $urandom;
    endtask

    task automatic newDReq(input bit loadOnly);
        iDReq = 1'b1;
        iDWrite = loadOnly ? 1'b0 : 1'($urandom_range(0, 1));
        iDByteEnable = 4'($urandom_range(1, 15));
        iDAddress = $urandom;
        iDWriteData = $urandom;
    endtask

    // Requester behaviour. Modes: 0 random, 1 both continuous,
    // 2 hold existing requests only, 3 D continuous loads with I quiet.
    task automatic applyStimulus(input int mode);
        bit ifl, dfl, rnd;
        ifl = mInflight && !mLastD && !readyI();
        dfl = mInflight && mLastD && !readyD();
        rnd = ($urandom_range(0, 2) == 0);
        if (readyI()) begin
            if (mode == 1 || (mode == 0 && rnd)) newIReq();
            else iIReq = 1'b0;
        end else if (ifl) begin
            iIAddress = $urandom;
        end else if (!iIReq && (mode == 1 || (mode == 0 && rnd))) begin
            newIReq();
        end
        rnd = ($urandom_range(0, 2) == 0);
        if (readyD()) begin
            if (mode == 1 || mode == 3 || (mode == 0 && rnd)) newDReq(mode == 3);
            else iDReq = 1'b0;
        end else if (dfl) begin
            iDAddress = $urandom;
            iDWriteData = $urandom;
            iDByteEnable = 4'($urandom);
            iDWrite = 1'($urandom);
        end else if (!iDReq && (mode == 1 || mode == 3 || (mode == 0 && rnd))) begin
            newDReq(mode == 3);
        end
    endtask

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic modelEdge();
        if (iRST) begin
            mInflight = 1'b0;
            mLastD = 1'b0;
            mWrite = 1'b0;
            mAddr = 32'd0;
            mBe = 4'd0;
            mWdata = 32'd0;
            mIrd = 32'd0;
            mDrd = 32'd0;
        end else if (mInflight) begin
            if (!mWrite && cyc == mG + RL) begin
                if (mLastD) mDrd = memWord(mAddr);
                else mIrd = memWord(mAddr);
            end
            if (cyc == mG + mLen + 1) mInflight = 1'b0;
        end else if (iIReq || iDReq) begin
            mLastD = (iIReq && iDReq) ? !mLastD : iDReq;
            mInflight = 1'b1;
            mG = cyc;
            if (mLastD) begin
                mWrite = iDWrite;
                mAddr = iDAddress;
                mBe = iDByteEnable;
                mWdata = iDWriteData;
            end else begin
                mWrite = 1'b0;
                mAddr = iIAddress;
                mBe = 4'b1111;
            end
            mLen = mWrite ? 1 : RL;
        end
    endtask

    task automatic stepCycle(input int mode);
        checkCycle();
        iRST = forceRst || (mode == 0 && $urandom_range(0, 149) == 0) ||
               (mode == 3 && mInflight && mLastD && !mWrite && cyc == mG + 2);
        if (mode == 3 && iRST) midRstDone = 1'b1;
        applyStimulus(mode);
        modelEdge();
        @(posedge iCLK);
        cyc++;
        @(negedge iCLK);
    endtask

    initial begin
        bit seen;
        iRST = 1'b1;
        iIReq = 1'b1;
        iIAddress = 32'h0040_0004;
        iDReq = 1'b0;
        iDWrite = 1'b0;
        iDByteEnable = 4'd0;
        iDAddress = 32'd0;
        iDWriteData = 32'd0;
        mInflight = 1'b0;
        mG = 0;
        mLen = RL;
        mLastD = 1'b0;
        mWrite = 1'b0;
        mAddr = 32'd0;
        mBe = 4'd0;
        mWdata = 32'd0;
        mIrd = 32'd0;
        mDrd = 32'd0;
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);

        // Reset cycle with a fetch already held, then the first fetch.
        forceRst = 1'b1;
        stepCycle(2);
        forceRst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (readyI()) begin
                checkOutput("fetch_data", oIReadData, 32'h00A0_0093);
                seen = 1'b1;
            end
            stepCycle(2);
        end
        checkOutput("fetch_seen", 32'(seen), 32'd1);

        // Directed store; load data on D must stay untouched.
        iDReq = 1'b1;
        iDWrite = 1'b1;
        iDAddress = 32'h1001_0008;
        iDByteEnable = 4'b0011;
        iDWriteData = 32'hDEAD_BEEF;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (expWen()) begin
                checkOutput("store_addr", oMemAddress, 32'h1001_0008);
                checkOutput("store_be", 32'(oMemByteEnable), 32'h3);
                checkOutput("store_wdata", oMemWriteData, 32'hDEAD_BEEF);
            end
            if (readyD()) seen = 1'b1;
            stepCycle(2);
        end
        checkOutput("store_seen", 32'(seen), 32'd1);

        // Both ports continuously busy, then random traffic with random resets.
        for (int k = 0; k < 40; k++) stepCycle(1);
        for (int k = 0; k < 600; k++) stepCycle(0);

        // Reset in the second ACCESS cycle of a D load, then a fresh conflict.
        for (int k = 0; k < 60 && !midRstDone; k++) stepCycle(3);
        checkOutput("mid_reset_hit", 32'(midRstDone), 32'd1);
        stepCycle(1);
        checkOutput("post_rst_grant", 32'(oGrantD), 32'd1);
        checkOutput("post_rst_drdata", oDReadData, 32'd0);
        for (int k = 0; k < 30; k++) stepCycle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
